// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accel_pkg
// Brief    : Direction codes, FSM states and axis sign convention shared by
//            the accelerometer tilt filter.
// Revision : 1.0 - initial release
// ============================================================================
package accel_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SUM      = 2'd1,
        ST_CLASSIFY = 2'd2,
        ST_EMIT     = 2'd3
    } state_t;

    localparam dir_t c_pos_x_dir = DIR_RIGHT;
    localparam dir_t c_neg_x_dir = DIR_LEFT;
    localparam dir_t c_pos_y_dir = DIR_UP;
    localparam dir_t c_neg_y_dir = DIR_DOWN;

    function automatic logic dir_is_y(input dir_t d);
        return (d == c_pos_y_dir) || (d == c_neg_y_dir);
    endfunction

endpackage
`default_nettype wire

// File: rtl/accel_sample_ram.sv
`default_nettype none
// ============================================================================
// Module   : accel_sample_ram
// Brief    : Simple dual-port sample window store; registered read returns the
//            old word when reading and writing the same address.
// Revision : 1.0 - initial release
// ============================================================================
module accel_sample_ram #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/accel_tilt_filter.sv
`default_nettype none
// ============================================================================
// Module   : accel_tilt_filter
// Brief    : Moving-average smoother for X/Y acceleration with dead-zone and
//            hysteresis steering classifier, valid/ready in and out.
// Revision : 1.0 - initial release
// ============================================================================
module accel_tilt_filter
    import accel_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LOG2_DEPTH = 3,
    parameter int DEAD_ZONE  = 64,
    parameter int HYST       = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y,
    output logic [2:0]        out_dir
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int ACC_W = DATA_W + LOG2_DEPTH;
    localparam int MAG_W = DATA_W + 1;

    localparam logic [LOG2_DEPTH:0] c_depth_cnt = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [MAG_W-1:0]    c_dz        = MAG_W'(DEAD_ZONE);
    localparam logic [MAG_W-1:0]    c_leave     = MAG_W'(DEAD_ZONE - HYST);
    localparam logic [MAG_W-1:0]    c_hyst      = MAG_W'(HYST);

    state_t                  state_q,  state_d;
    logic                    active_q;
    logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH:0]     fill_q,   fill_d;
    logic [ACC_W-1:0]        sum_x_q,  sum_x_d;
    logic [ACC_W-1:0]        sum_y_q,  sum_y_d;
    logic [DATA_W-1:0]       new_x_q,  new_x_d;
    logic [DATA_W-1:0]       new_y_q,  new_y_d;
    logic [DATA_W-1:0]       out_x_q,  out_x_d;
    logic [DATA_W-1:0]       out_y_q,  out_y_d;
    dir_t                    dir_q,    dir_d;

    logic                    w_accept;
    logic                    w_full;
    logic [2*DATA_W-1:0]     w_rd_data;
    logic [DATA_W-1:0]       w_old_x,  w_old_y;
    logic [DATA_W-1:0]       w_avg_x,  w_avg_y;
    logic [MAG_W-1:0]        w_mag_x,  w_mag_y;
    logic [MAG_W-1:0]        w_dom_mag, w_cur_mag, w_oth_mag;
    dir_t                    w_cand_x, w_cand_y;
    dir_t                    w_dom_cand, w_cur_cand, w_oth_cand;
    dir_t                    w_dir_next;
    logic                    w_cur_is_y, w_y_dom;

    // |v| with the most-negative code clamped so the result stays positive.
    function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] v);
        if (v == {1'b1, {(DATA_W-1){1'b0}}}) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

    assign w_accept = in_valid && in_ready;
    assign w_full   = (fill_q == c_depth_cnt);

    accel_sample_ram #(
        .WORD_W (2*DATA_W),
        .ADDR_W (LOG2_DEPTH)
    ) u_ram (
        .clk_i   (clk_clk),
        .we_i    (w_accept),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_x, in_y}),
        .re_i    (w_accept),
        .raddr_i (wr_ptr_q),
        .rdata_o (w_rd_data)
    );

    // Slots not yet written this fill cycle contribute nothing to the sum.
    assign w_old_x = w_full ? w_rd_data[2*DATA_W-1:DATA_W] : '0;
    assign w_old_y = w_full ? w_rd_data[DATA_W-1:0]        : '0;

    // Dropping the low bits of a two's-complement sum is a floor division.
    assign w_avg_x = sum_x_q[ACC_W-1:LOG2_DEPTH];
    assign w_avg_y = sum_y_q[ACC_W-1:LOG2_DEPTH];
    assign w_mag_x = {1'b0, sat_abs(w_avg_x)};
    assign w_mag_y = {1'b0, sat_abs(w_avg_y)};

    always_comb begin
        w_cand_x   = w_avg_x[DATA_W-1] ? c_neg_x_dir : c_pos_x_dir;
        w_cand_y   = w_avg_y[DATA_W-1] ? c_neg_y_dir : c_pos_y_dir;
        w_cur_is_y = dir_is_y(dir_q);
        if (w_mag_y > w_mag_x) begin
            w_y_dom = 1'b1;
        end else if (w_mag_x > w_mag_y) begin
            w_y_dom = 1'b0;
        end else begin
            w_y_dom = w_cur_is_y;
        end
        w_dom_mag  = w_y_dom    ? w_mag_y  : w_mag_x;
        w_dom_cand = w_y_dom    ? w_cand_y : w_cand_x;
        w_cur_mag  = w_cur_is_y ? w_mag_y  : w_mag_x;
        w_cur_cand = w_cur_is_y ? w_cand_y : w_cand_x;
        w_oth_mag  = w_cur_is_y ? w_mag_x  : w_mag_y;
        w_oth_cand = w_cur_is_y ? w_cand_x : w_cand_y;

        w_dir_next = dir_q;
        if (dir_q == DIR_NONE) begin
            if (w_dom_mag >= c_dz) begin
                w_dir_next = w_dom_cand;
            end
        end else if (w_cur_mag < c_leave) begin
            w_dir_next = DIR_NONE;
        end else if ((w_oth_mag > w_cur_mag + c_hyst) && (w_oth_mag >= c_dz)) begin
            w_dir_next = w_oth_cand;
        end else if ((w_cur_cand != dir_q) && (w_cur_mag >= c_dz)) begin
            w_dir_next = w_cur_cand;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        sum_x_d   = sum_x_q;
        sum_y_d   = sum_y_q;
        new_x_d   = new_x_q;
        new_y_d   = new_y_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        dir_d     = dir_q;
        in_ready  = (state_q == ST_IDLE) && active_q;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    new_x_d = in_x;
                    new_y_d = in_y;
                    state_d = ST_SUM;
                end
            end
            ST_SUM: begin
                sum_x_d  = sum_x_q + {{LOG2_DEPTH{new_x_q[DATA_W-1]}}, new_x_q}
                                   - {{LOG2_DEPTH{w_old_x[DATA_W-1]}}, w_old_x};
                sum_y_d  = sum_y_q + {{LOG2_DEPTH{new_y_q[DATA_W-1]}}, new_y_q}
                                   - {{LOG2_DEPTH{w_old_y[DATA_W-1]}}, w_old_y};
                wr_ptr_d = wr_ptr_q + 1'b1;
                fill_d   = w_full ? fill_q : fill_q + 1'b1;
                state_d  = ST_CLASSIFY;
            end
            ST_CLASSIFY: begin
                out_x_d = w_avg_x;
                out_y_d = w_avg_y;
                dir_d   = w_dir_next;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (w_full) begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_x_q  <= '0;
            sum_y_q  <= '0;
            new_x_q  <= '0;
            new_y_q  <= '0;
            out_x_q  <= '0;
            out_y_q  <= '0;
            dir_q    <= DIR_NONE;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            sum_x_q  <= sum_x_d;
            sum_y_q  <= sum_y_d;
            new_x_q  <= new_x_d;
            new_y_q  <= new_y_d;
            out_x_q  <= out_x_d;
            out_y_q  <= out_y_d;
            dir_q    <= dir_d;
        end
    end

    assign out_x   = out_x_q;
    assign out_y   = out_y_q;
    assign out_dir = dir_q;

endmodule
`default_nettype wire
